// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch after IF_STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned IF_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        stall_o,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned CW = $clog2(IF_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(IF_STARVE_MAX);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_RESP = 2'd1;
  localparam logic [1:0] D_RESP  = 2'd2;
  localparam logic [1:0] RMW_WR  = 2'd3;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] starve_cnt;

  logic [31:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic [1:0]    lat_size;
  logic          lat_we;
  logic          lat_err;

  logic          d_mis;
  logic          if_force;
  logic          if_win;
  logic          d_win;
  logic [31:0]   merged;

  always_comb begin
    d_mis = 1'b0;
    case (d_size)
      2'b00:   d_mis = 1'b0;
      2'b01:   d_mis = d_addr[0];
      2'b10:   d_mis = (d_addr[1:0] != 2'b00);
      default: d_mis = 1'b1;
    endcase
  end

  // Grants are gated by rst so nothing escapes while reset is held.
  always_comb begin
    if_force = if_req && (starve_cnt == STARVE_MAX);
    if_win   = !rst && (state == IDLE) && if_req && (!d_req || if_force);
    d_win    = !rst && (state == IDLE) && d_req && !if_force;
  end

  // Sub-word store merge: lat_wdata is LSB-aligned, lanes chosen by latched address.
  always_comb begin
    merged = ram_rdata;
    if (lat_size == 2'b00) begin
      case (lat_addr[1:0])
        2'b00:   merged[7:0]   = lat_wdata[7:0];
        2'b01:   merged[15:8]  = lat_wdata[7:0];
        2'b10:   merged[23:16] = lat_wdata[7:0];
        default: merged[31:24] = lat_wdata[7:0];
      endcase
    end else begin
      if (lat_addr[1]) merged[31:16] = lat_wdata[15:0];
      else             merged[15:0]  = lat_wdata[15:0];
    end
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_done    = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (if_win) begin
          if_gnt    = 1'b1;
          ram_ce    = 1'b1;
          ram_addr  = if_addr & WORD_MASK;
          state_nxt = IF_RESP;
        end else if (d_win) begin
          d_gnt     = 1'b1;
          state_nxt = D_RESP;
          if (!d_mis) begin
            ram_ce   = 1'b1;
            ram_addr = d_addr & WORD_MASK;
            if (d_we && d_size == 2'b10) begin
              ram_we    = 1'b1;
              ram_wdata = d_wdata;
            end else if (d_we) begin
              state_nxt = RMW_WR;
            end
          end
        end
      end
      IF_RESP: begin
        if_rvalid = 1'b1;
        if_rdata  = ram_rdata;
        state_nxt = IDLE;
      end
      RMW_WR: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = lat_addr & WORD_MASK;
        ram_wdata = merged;
        state_nxt = D_RESP;
      end
      D_RESP: begin
        d_done    = 1'b1;
        d_err     = lat_err;
        d_rdata   = (lat_we || lat_err) ? '0 : ram_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_o = d_req && !d_done && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (d_win) begin
      if (!if_req)                       starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
    end else if (d_win) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata[15:0];
      lat_size  <= d_size;
      lat_we    <= d_we;
      lat_err   <= d_mis;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: loads, word/sub-word stores, misalignment,
// fetch, starvation pattern and reset abort of a read-modify-write.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        stall_o;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];
  int          we_count;
  int          we_snap;
  int          checks;
  int          errors;
  logic [1:0]  exp_gnt;

  mem_arbiter #(.IF_STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err),
    .d_rdata(d_rdata), .stall_o(stall_o),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read single-port RAM
  initial begin
    ram_rdata = '0;
    we_count  = 0;
  end
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        mem[ram_addr[9:2]] <= ram_wdata;
        we_count <= we_count + 1;
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic dreq(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_size  = sz;
    d_addr  = a;
    d_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h40;
    dreq(1'b0, 2'b10, 32'h100, 32'h0);
    #1 rst = 1'b1;
    #2;
    chk("rst_d_gnt",   d_gnt,   0);
    chk("rst_if_gnt",  if_gnt,  0);
    chk("rst_ram_ce",  ram_ce,  0);
    chk("rst_ram_we",  ram_we,  0);
    chk("rst_stall",   stall_o, 0);
    chk("rst_d_done",  d_done,  0);
    @(negedge clk); @(negedge clk); #2;
    chk("rst_hold_ce", ram_ce,  0);
    chk("rst_hold_rv", if_rvalid, 0);

    // SW 0x100 in the first cycle after reset release
    @(negedge clk); rst = 1'b0; if_req = 1'b0;
    dreq(1'b1, 2'b10, 32'h100, 32'hDEADBEEF); #2;
    chk("sw_gnt",   d_gnt,     1);
    chk("sw_ce",    ram_ce,    1);
    chk("sw_we",    ram_we,    1);
    chk("sw_addr",  ram_addr,  32'h100);
    chk("sw_wdata", ram_wdata, 32'hDEADBEEF);
    chk("sw_stall", stall_o,   1);
    @(negedge clk); d_req = 1'b0; #2;
    chk("sw_done",  d_done, 1);
    chk("sw_err",   d_err,  0);
    chk("sw_resp_ce", ram_ce, 0);

    // LW 0x100
    @(negedge clk); dreq(1'b0, 2'b10, 32'h100, 32'h0); #2;
    chk("lw_gnt",  d_gnt,    1);
    chk("lw_ce",   ram_ce,   1);
    chk("lw_we",   ram_we,   0);
    chk("lw_addr", ram_addr, 32'h100);
    @(negedge clk); d_req = 1'b0; #2;
    chk("lw_done",  d_done,  1);
    chk("lw_rdata", d_rdata, 32'hDEADBEEF);
    chk("lw_err",   d_err,   0);

    // SW 0x200 = 0x11223344
    @(negedge clk); dreq(1'b1, 2'b10, 32'h200, 32'h11223344); #2;
    chk("sw2_we", ram_we, 1);
    @(negedge clk); d_req = 1'b0; #2;
    chk("sw2_done", d_done, 1);

    // SB 0x203 0xAA
    @(negedge clk); dreq(1'b1, 2'b00, 32'h203, 32'hAA); #2;
    chk("sb_gnt",  d_gnt,    1);
    chk("sb_ce",   ram_ce,   1);
    chk("sb_we0",  ram_we,   0);
    chk("sb_addr", ram_addr, 32'h200);
    @(negedge clk); d_req = 1'b0; #2;
    chk("sb_we1",    ram_we,    1);
    chk("sb_waddr",  ram_addr,  32'h200);
    chk("sb_wdata",  ram_wdata, 32'hAA223344);
    chk("sb_nodone", d_done,    0);
    @(negedge clk); #2;
    chk("sb_done", d_done, 1);
    chk("sb_ce2",  ram_ce, 0);

    // restore 0x200, then SH 0x202 0xBEEF
    @(negedge clk); dreq(1'b1, 2'b10, 32'h200, 32'h11223344); #2;
    @(negedge clk); d_req = 1'b0; #2;
    chk("sw3_done", d_done, 1);
    @(negedge clk); dreq(1'b1, 2'b01, 32'h202, 32'hBEEF); #2;
    chk("sh_gnt", d_gnt, 1);
    @(negedge clk); d_req = 1'b0; #2;
    chk("sh_we",    ram_we,    1);
    chk("sh_wdata", ram_wdata, 32'hBEEF3344);
    @(negedge clk); #2;
    chk("sh_done", d_done, 1);

    // misaligned: SH 0x201, LW 0x102, size 11
    @(negedge clk); dreq(1'b1, 2'b01, 32'h201, 32'h1234); #2;
    chk("mis_sh_gnt", d_gnt,  1);
    chk("mis_sh_ce",  ram_ce, 0);
    @(negedge clk); d_req = 1'b0; #2;
    chk("mis_sh_done", d_done, 1);
    chk("mis_sh_err",  d_err,  1);
    chk("mis_sh_ce2",  ram_ce, 0);
    @(negedge clk); dreq(1'b0, 2'b10, 32'h102, 32'h0); #2;
    chk("mis_lw_ce", ram_ce, 0);
    @(negedge clk); d_req = 1'b0; #2;
    chk("mis_lw_err", d_err, 1);
    @(negedge clk); dreq(1'b0, 2'b11, 32'h100, 32'h0); #2;
    @(negedge clk); d_req = 1'b0; #2;
    chk("mis_sz_err", d_err, 1);
    @(negedge clk); #2;
    chk("err_idle", d_err, 0);

    // fetch 0x40
    dreq(1'b1, 2'b10, 32'h40, 32'h12345678);
    @(negedge clk); d_req = 1'b0; #2;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #2;
    chk("if_gnt",   if_gnt,   1);
    chk("if_ce",    ram_ce,   1);
    chk("if_we",    ram_we,   0);
    chk("if_addr",  ram_addr, 32'h40);
    chk("if_stall", stall_o,  0);
    @(negedge clk); if_req = 1'b0; #2;
    chk("if_rvalid", if_rvalid, 1);
    chk("if_rdata",  if_rdata,  32'h12345678);
    chk("if_stall2", stall_o,   0);

    // both requesters held: D,D,D,D,IF repeating, grant every other cycle
    @(negedge clk); dreq(1'b0, 2'b10, 32'h100, 32'h0); if_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      exp_gnt = (k % 2 != 0) ? 2'b00 : (((k / 2) % 5 == 4) ? 2'b10 : 2'b01);
      chk($sformatf("arb_k%0d", k), {30'd0, if_gnt, d_gnt}, {30'd0, exp_gnt});
    end
    @(negedge clk); d_req = 1'b0; if_req = 1'b0; #2;

    // reset during the write phase of SB 0x203
    @(negedge clk); dreq(1'b1, 2'b00, 32'h203, 32'h55); #2;
    chk("rmw_gnt", d_gnt, 1);
    @(negedge clk); d_req = 1'b0; rst = 1'b1; we_snap = we_count; #2;
    chk("rmw_rst_we",    ram_we,    0);
    chk("rmw_rst_ce",    ram_ce,    0);
    chk("rmw_rst_wdata", ram_wdata, 0);
    chk("rmw_rst_done",  d_done,    0);
    @(negedge clk); rst = 1'b0; #2;
    chk("rmw_post_done", d_done, 0);
    chk("rmw_post_we",   ram_we, 0);
    @(negedge clk); #2;
    chk("rmw_we_count", we_count, we_snap);
    @(negedge clk); dreq(1'b0, 2'b10, 32'h200, 32'h0); #2;
    chk("post_rst_gnt", d_gnt, 1);
    @(negedge clk); d_req = 1'b0; #2;
    chk("post_rst_done",  d_done,  1);
    chk("post_rst_rdata", d_rdata, 32'hBEEF3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: IF_STARVE_MAX, 4, max consecutive data grants while if_req is pending before one fetch grant is forced (>=1).
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: if_req  in  1  fetch request; if_addr  in  32  fetch byte address.
REQ-005 SHALL have port: if_gnt  out  1  fetch granted this cycle; if_rvalid  out  1  fetch data valid; if_rdata  out  32  fetch word.
REQ-006 SHALL have port: d_req  in  1  data request; d_we  in  1  1=store; d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port: d_addr  in  32  data byte address; d_wdata  in  32  store data, LSB-aligned.
REQ-008 SHALL have port: d_gnt  out  1  data granted; d_done  out  1  data op complete; d_err  out  1  misaligned/illegal, valid with d_done; d_rdata  out  32  raw load word, valid with d_done.
REQ-009 SHALL have port: stall_o  out  1  pipeline stall while a data request is not yet done.
REQ-010 SHALL have port: ram_ce  out  1; ram_we  out  1; ram_addr  out  32  word-aligned; ram_wdata  out  32; ram_rdata  in  32  single-port unified memory, synchronous read, data valid cycle after ram_ce&~ram_we.

Function
REQ-011 SHALL implement FSM states IDLE, IF_RESP, D_RESP, RMW_WR; at most one ram access per cycle.
REQ-012 SHALL grant only in IDLE; requesters hold req and payload stable until gnt; payload sampled and latched in the grant cycle.
REQ-013 IDLE arbitration SHALL be: d_req wins, except when if_req=1 and starve_cnt==IF_STARVE_MAX, then if_req wins.
REQ-014 starve_cnt SHALL increment on a data grant with if_req=1, clear on any fetch grant or a data grant with if_req=0, never exceed IF_STARVE_MAX.
REQ-015 Fetch grant cycle SHALL drive ram_ce=1, ram_we=0, ram_addr={if_addr[31:2],2'b00}; next state IF_RESP with if_rvalid=1, if_rdata=ram_rdata; then IDLE.
REQ-016 Misaligned SHALL mean: d_size=11, half with addr[0]=1, or word with addr[1:0]!=0; misaligned grant SHALL drive no ram access, next cycle D_RESP with d_done=1, d_err=1.
REQ-017 Aligned load grant cycle SHALL issue word read at {d_addr[31:2],2'b00}; D_RESP SHALL give d_done=1, d_rdata=ram_rdata; lane extraction/sign extension belongs to the mem stage.
REQ-018 Word store grant cycle SHALL drive ram_ce=1, ram_we=1, ram_wdata=d_wdata; next cycle D_RESP with d_done=1.
REQ-019 Byte/half store grant cycle SHALL issue read of aligned word, then RMW_WR drives ram_we=1 with merged word, then D_RESP with d_done=1 (3 cycles total).
REQ-020 Merge SHALL be: byte replaces lane addr[1:0] with wdata[7:0]; half replaces lanes 1:0 (addr[1]=0) or 3:2 (addr[1]=1) with wdata[15:0]; other lanes kept from ram_rdata.
REQ-021 IF_RESP and D_RESP SHALL return to IDLE and issue no grant or ram access in that cycle.
REQ-022 stall_o SHALL equal d_req & ~d_done, combinational.
REQ-023 d_err SHALL be 0 whenever d_done=0; if_gnt and d_gnt never both 1.
REQ-024 ram_ce=0 and ram_we=0 SHALL hold in every cycle without an access defined above.

Reset
REQ-025 rst=1 SHALL force state IDLE, starve_cnt=0, latched payload 0, all outputs 0 immediately, independent of clk.
REQ-026 rst during a pending RMW SHALL abort it: no ram_we after reset, no d_done for the aborted op.
REQ-027 First grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-028 LW 0x100, ram word 0xDEADBEEF -> cycle0 d_gnt, ram_ce=1 ram_we=0 addr 0x100; cycle1 d_done=1 d_rdata=0xDEADBEEF d_err=0.
REQ-029 SB 0x203 wdata 0xAA, ram 0x11223344 -> cycle0 read 0x200; cycle1 ram_we=1 wdata 0xAA223344; cycle2 d_done=1.
REQ-030 SH 0x202 wdata 0xBEEF, ram 0x11223344 -> cycle1 write 0xBEEF3344; SH 0x201 -> no ram access, d_done=1 d_err=1.
REQ-031 if_req and d_req held high, IF_STARVE_MAX=4 -> grant pattern D,D,D,D,IF repeating; never two grants in one cycle.
REQ-032 rst pulsed in cycle1 of SB 0x203 -> no ram_we in any later cycle, all outputs 0, next request granted normally.
REQ-033 Fetch 0x40 while d_req=0 -> if_gnt cycle0, if_rvalid=1 with ram word cycle1, stall_o=0 throughout.
